// File: rtl/mips_trace_buffer_pkg.sv
// rtl/mips_trace_buffer_pkg.sv - shared definitions for the writeback trace buffer
package mips_trace_buffer_pkg;

    typedef enum logic {
        ST_ARMED   = 1'b0,
        ST_CAPTURE = 1'b1
    } trace_state_e;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_W   = 5;
    localparam int DEF_ENTRY_W = DEF_DATA_W + DEF_REG_W + DEF_DATA_W;

    // Entry layout, MSB to LSB: {pc, wr, wd}
    function automatic int entry_width(input int data_w, input int reg_w);
        return data_w + reg_w + data_w;
    endfunction

    function automatic int wd_lsb();
        return 0;
    endfunction

    function automatic int wr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int pc_lsb(input int data_w, input int reg_w);
        return data_w + reg_w;
    endfunction

endpackage

// File: rtl/mips_trace_ram.sv
// rtl/mips_trace_ram.sv - trace storage, one write port and one asynchronous read port
module mips_trace_ram #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 69,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [PTR_W-1:0]   waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]   raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_trace_buffer.sv
// rtl/mips_trace_buffer.sv - triggered capture of CPU register writebacks into a show-ahead FIFO
module mips_trace_buffer
    import mips_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic              wrap_mode,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic              we_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [REG_W-1:0]  wr_in,
    input  logic [DATA_W-1:0] wd_in,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_pc,
    output logic [REG_W-1:0]  rd_wr,
    output logic [DATA_W-1:0] rd_wd,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              overflow,
    output logic              triggered
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = entry_width(DATA_W, REG_W);
    localparam int WD_LSB  = wd_lsb();
    localparam int WR_LSB  = wr_lsb(DATA_W);
    localparam int PC_LSB  = pc_lsb(DATA_W, REG_W);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    trace_state_e       state_q, state_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic               trig_hit, push, pop, is_full, ram_we;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    // Start condition; the triggering writeback is pushed in the same cycle
    assign trig_hit = en && (!trig_en || (we_in && (pc_in == trig_pc)));
    assign is_full  = (count_q == DEPTH_C);
    assign push     = en && we_in && ((state_q == ST_CAPTURE) || trig_hit);
    assign pop      = rd_valid && rd_ready;
    assign ram_we   = !clear && push && (!is_full || pop || wrap_mode);
    assign wr_entry = {pc_in, wr_in, wd_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_ARMED;
        end else if (state_q == ST_ARMED && trig_hit) begin
            state_d = ST_CAPTURE;
        end
    end

    always_comb begin
        triggered = (state_q == ST_CAPTURE);
    end

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (pop) begin
                rptr_d  = rptr_q + PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
            if (push) begin
                if (!is_full || pop) begin
                    wptr_d  = wptr_q + PTR_W'(1);
                    count_d = count_d + CNT_W'(1);
                end else if (wrap_mode) begin
                    // Overwrite the oldest slot: both pointers move, count stays at DEPTH
                    wptr_d = wptr_q + PTR_W'(1);
                    rptr_d = rptr_q + PTR_W'(1);
                    ovf_d  = 1'b1;
                end else begin
                    ovf_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    mips_trace_ram #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rptr_q),
        .rdata_o (rd_entry)
    );

    assign rd_valid = (count_q != '0);
    assign rd_pc    = rd_entry[PC_LSB +: DATA_W];
    assign rd_wr    = rd_entry[WR_LSB +: REG_W];
    assign rd_wd    = rd_entry[WD_LSB +: DATA_W];
    assign count    = count_q;
    assign full     = is_full;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb/tb_mips_trace_buffer.sv - directed vector bench for mips_trace_buffer
module tb_mips_trace_buffer;

    logic        clk = 1'b0;
    logic        reset, clear, en, wrap_mode, trig_en, we_in, rd_ready;
    logic [31:0] trig_pc, pc_in, wd_in;
    logic [4:0]  wr_in;
    logic        rd_valid, full, overflow, triggered;
    logic [31:0] rd_pc, rd_wd;
    logic [4:0]  rd_wr;
    logic [4:0]  count;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_trace_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .en        (en),
        .wrap_mode (wrap_mode),
        .trig_en   (trig_en),
        .trig_pc   (trig_pc),
        .we_in     (we_in),
        .pc_in     (pc_in),
        .wr_in     (wr_in),
        .wd_in     (wd_in),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_pc     (rd_pc),
        .rd_wr     (rd_wr),
        .rd_wd     (rd_wd),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .triggered (triggered)
    );

    typedef struct {
        logic        clr, en, tren, we, rdy;
        logic [31:0] pc;
        int          exp_cnt;
        logic        exp_valid, exp_trig, exp_ovf, chk_pc;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; en = 1'b0; wrap_mode = 1'b0; trig_en = 1'b0;
        we_in = 1'b0; rd_ready = 1'b0; pc_in = '0; wr_in = '0; wd_in = '0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Push wd = first..last back to back, pc = 4*wd, wr = low bits of wd
    task automatic push_run(input int first, input int last);
        en = 1'b1; we_in = 1'b1; rd_ready = 1'b0;
        for (int i = first; i <= last; i++) begin
            wd_in = 32'(i); pc_in = 32'(i * 4); wr_in = 5'(i);
            tick();
        end
        we_in = 1'b0;
    endtask

    task automatic drain_check(input string name, input int first, input int last);
        we_in = 1'b0; rd_ready = 1'b1;
        for (int i = first; i <= last; i++) begin
            check({name, "_valid"}, 32'(rd_valid), 32'd1);
            check({name, "_wd"}, rd_wd, 32'(i));
            tick();
        end
        rd_ready = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1,0,0,0,0, 32'h00, 0, 0,0,0, 0, 32'h00};
        vt[1]  = '{0,1,0,1,0, 32'h00, 1, 1,1,0, 1, 32'h00};
        vt[2]  = '{0,1,0,1,0, 32'h04, 2, 1,1,0, 1, 32'h00};
        vt[3]  = '{0,1,0,1,0, 32'h08, 3, 1,1,0, 1, 32'h00};
        vt[4]  = '{0,1,0,0,0, 32'h00, 3, 1,1,0, 1, 32'h00};
        vt[5]  = '{0,1,0,0,1, 32'h00, 2, 1,1,0, 1, 32'h04};
        vt[6]  = '{0,1,0,0,1, 32'h00, 1, 1,1,0, 1, 32'h08};
        vt[7]  = '{0,1,0,0,1, 32'h00, 0, 0,1,0, 0, 32'h00};
        vt[8]  = '{1,0,0,0,0, 32'h00, 0, 0,0,0, 0, 32'h00};
        vt[9]  = '{0,1,1,1,0, 32'h10, 0, 0,0,0, 0, 32'h00};
        vt[10] = '{0,1,1,1,0, 32'h14, 0, 0,0,0, 0, 32'h00};
        vt[11] = '{0,1,1,1,0, 32'h20, 1, 1,1,0, 1, 32'h20};
        vt[12] = '{0,1,1,1,0, 32'h24, 2, 1,1,0, 1, 32'h20};
        vt[13] = '{0,0,1,1,0, 32'h28, 2, 1,1,0, 1, 32'h20};

        idle_inputs();
        trig_pc = 32'h20;
        reset = 1'b0;
        #12;
        check("reset_count", 32'(count), 32'd0);
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_trig", 32'(triggered), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Capture/drain and trigger vectors
        for (int v = 0; v < 14; v++) begin
            clear = vt[v].clr; en = vt[v].en; trig_en = vt[v].tren;
            we_in = vt[v].we; rd_ready = vt[v].rdy; pc_in = vt[v].pc;
            wr_in = 5'(v); wd_in = 32'(v + 100);
            tick();
            check($sformatf("v%0d_count", v), 32'(count), 32'(vt[v].exp_cnt));
            check($sformatf("v%0d_valid", v), 32'(rd_valid), 32'(vt[v].exp_valid));
            check($sformatf("v%0d_trig", v), 32'(triggered), 32'(vt[v].exp_trig));
            check($sformatf("v%0d_ovf", v), 32'(overflow), 32'(vt[v].exp_ovf));
            if (vt[v].chk_pc) check($sformatf("v%0d_rdpc", v), rd_pc, vt[v].exp_pc);
        end

        // Stop mode: entries beyond DEPTH are dropped
        do_clear();
        wrap_mode = 1'b0;
        push_run(1, 18);
        check("stop_count", 32'(count), 32'd16);
        check("stop_full", 32'(full), 32'd1);
        check("stop_ovf", 32'(overflow), 32'd1);
        check("stop_head_pc", rd_pc, 32'd4);
        check("stop_head_wr", 32'(rd_wr), 32'd1);
        drain_check("stop", 1, 16);
        check("stop_empty", 32'(rd_valid), 32'd0);
        check("stop_ovf_sticky", 32'(overflow), 32'd1);

        // Clear mid-capture wins over a concurrent push
        push_run(1, 2);
        clear = 1'b1; en = 1'b1; we_in = 1'b1; rd_ready = 1'b1;
        tick();
        clear = 1'b0; we_in = 1'b0; rd_ready = 1'b0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_trig", 32'(triggered), 32'd0);
        check("clr_valid", 32'(rd_valid), 32'd0);

        // Wrap mode: oldest entries overwritten
        do_clear();
        wrap_mode = 1'b1;
        push_run(1, 18);
        check("wrap_count", 32'(count), 32'd16);
        check("wrap_full", 32'(full), 32'd1);
        check("wrap_ovf", 32'(overflow), 32'd1);
        check("wrap_head_wr", 32'(rd_wr), 32'd3);
        drain_check("wrap", 3, 18);
        check("wrap_empty", 32'(rd_valid), 32'd0);

        // Full buffer with simultaneous push and pop
        do_clear();
        wrap_mode = 1'b0;
        push_run(1, 16);
        check("pp_full", 32'(full), 32'd1);
        en = 1'b1; we_in = 1'b1; rd_ready = 1'b1;
        wd_in = 32'd100; pc_in = 32'h190; wr_in = 5'd7;
        check("pp_popped_oldest", rd_wd, 32'd1);
        tick();
        we_in = 1'b0; rd_ready = 1'b0;
        check("pp_count", 32'(count), 32'd16);
        check("pp_ovf", 32'(overflow), 32'd0);
        drain_check("pp", 2, 16);
        check("pp_last_wd", rd_wd, 32'd100);
        check("pp_last_wr", 32'(rd_wr), 32'd7);

        // Asynchronous reset between clock edges
        do_clear();
        push_run(1, 17);
        check("prerst_ovf", 32'(overflow), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(rd_valid), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_trig", 32'(triggered), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        tick();
        check("post_rst_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_trace_buffer.md
MIPS_TRACE_BUFFER -- requirements
Module: mips_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry count, power of two, 4..256.
REQ-002 SHALL have parameter DATA_W, default 32: width of PC and write-data fields.
REQ-003 SHALL have parameter REG_W, default 5: width of the register-index field.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clear, input, 1: synchronous flush and re-arm.
REQ-007 SHALL have port en, input, 1: capture enable.
REQ-008 SHALL have port wrap_mode, input, 1: 1 selects overwrite-oldest; 0 selects stop-when-full.
REQ-009 SHALL have port trig_en, input, 1: when 1, capture starts only on a PC match.
REQ-010 SHALL have port trig_pc, input, DATA_W: trigger PC value.
REQ-011 SHALL have port we_in, input, 1: CPU register-writeback strobe.
REQ-012 SHALL have port pc_in, input, DATA_W: PC of the retiring instruction.
REQ-013 SHALL have port wr_in, input, REG_W: write-register index.
REQ-014 SHALL have port wd_in, input, DATA_W: write-back data.
REQ-015 SHALL have port rd_ready, input, 1: consumer accepts the head entry.
REQ-016 SHALL have port rd_valid, output, 1: head entry is present.
REQ-017 SHALL have ports rd_pc (DATA_W), rd_wr (REG_W) and rd_wd (DATA_W), all outputs: the head entry.
REQ-018 SHALL have port count, output, $clog2(DEPTH)+1: number of stored entries.
REQ-019 SHALL have ports full, overflow and triggered, all 1-bit outputs: full status, sticky entry-loss flag, and capture active.

Function
REQ-020 SHALL implement a two-state FSM: ARMED and CAPTURE.
REQ-021 ARMED to CAPTURE transitions:
- with en=1 and trig_en=0, on the first cycle in that condition;
- with en=1 and trig_en=1, on the first cycle with we_in=1 and pc_in==trig_pc.
REQ-022 The triggering writeback SHALL itself be captured.
REQ-023 triggered SHALL equal 1 exactly while in CAPTURE.
REQ-024 A push SHALL occur when in CAPTURE (or on the triggering cycle), en=1 and we_in=1; it stores {pc_in, wr_in, wd_in}.
REQ-025 en=0 in CAPTURE SHALL suppress pushes without leaving CAPTURE.
REQ-026 A pop SHALL occur when rd_valid=1 and rd_ready=1; rd_* SHALL then advance to the next-oldest entry on the following cycle.
REQ-027 The buffer SHALL be show-ahead:
- rd_* present the oldest entry combinationally from storage;
- rd_valid = (count != 0);
- an entry pushed into an empty buffer is visible one cycle after the push edge.
REQ-028 On a simultaneous push and pop, count SHALL be unchanged; this includes the full state, with no overwrite and no overflow.
REQ-029 In stop mode with full=1 and no pop, a push SHALL be dropped and overflow set; stored entries are unchanged.
REQ-030 In wrap mode with full=1 and no pop, a push SHALL overwrite the oldest entry, advance the read pointer, keep count=DEPTH and set overflow.
REQ-031 rd_* MAY change while rd_valid=1 and rd_ready=0 only in the wrap-overwrite case.
REQ-032 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-033 full SHALL equal (count == DEPTH).
REQ-034 overflow SHALL remain set until clear or reset.
REQ-035 clear=1 SHALL take priority over push and pop:
- count, pointers and overflow go to 0;
- state goes to ARMED;
- storage contents are don't-care.
REQ-036 A change of wrap_mode mid-capture SHALL affect only subsequent pushes.

Reset
REQ-037 reset=0 SHALL asynchronously set state=ARMED, pointers=0, count=0, overflow=0, triggered=0, rd_valid=0 and full=0.
REQ-038 Storage SHALL NOT be reset.
REQ-039 rd_pc, rd_wr and rd_wd are don't-care while rd_valid=0.
REQ-040 Deassertion of reset SHALL be synchronised to clk outside this block.
REQ-041 A reset mid-capture SHALL discard all entries.

Structure
REQ-042 A shared definitions package SHALL hold:
- FSM state encodings;
- the trace entry width DATA_W+REG_W+DATA_W (69 at defaults);
- field-offset constants for packing and unpacking.
REQ-043 Storage SHALL be one sub-module, mips_trace_ram: DEPTH x entry-width, one write port and one asynchronous read port, no reset.
REQ-044 FSM, pointers, counter and flags SHALL live in mips_trace_buffer.

Verification
REQ-045 Basic capture and drain: DEPTH=16, trig_en=0, en=1; push 3 writebacks (pc=0x0,0x4,0x8) with rd_ready=0, then rd_ready=1 -> count=3, then rd_pc reads 0x0, 0x4, 0x8 on successive cycles, rd_valid=0 afterwards.
REQ-046 Trigger: trig_en=1, trig_pc=0x20; writebacks at pc=0x10,0x14,0x20,0x24 -> triggered rises at the pc=0x20 edge, count=2, head rd_pc=0x20.
REQ-047 Stop mode: wrap_mode=0; 18 pushes with wd=1..18, no pops -> count=16, full=1, overflow=1, drained wd sequence 1..16.
REQ-048 Wrap mode: wrap_mode=1; 18 pushes with wd=1..18 -> count=16, overflow=1, drained wd sequence 3..18.
REQ-049 Full with simultaneous push and pop: buffer full, one push plus one pop in the same cycle -> count stays 16, overflow stays 0, popped entry is the oldest.
REQ-050 Clear and reset: clear=1 mid-capture -> count=0, overflow=0, triggered=0 next cycle; reset=0 pulse between clk edges -> all status outputs 0 immediately.
